// File: rtl/bin2bcd_msd_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives start/din; the slave (converter) returns status and result.
interface bin2bcd_msd_if #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
);
    logic                       start;
    logic [W-1:0]               din;
    logic                       busy;
    logic                       done;
    logic [4*D-1:0]             bcd;
    logic [3:0]                 msd;
    logic [$clog2(D+1)-1:0]     ndig;

    modport master (
        output start,
        output din,
        input  busy,
        input  done,
        input  bcd,
        input  msd,
        input  ndig
    );

    modport slave (
        input  start,
        input  din,
        output busy,
        output done,
        output bcd,
        output msd,
        output ndig
    );
endinterface

// File: rtl/bin2bcd_msd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, which also
// reports the most significant non-zero digit and the count of significant digits.
module bin2bcd_msd #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bin2bcd_msd_if.slave     bus
);
    localparam int unsigned BW = 4 * D;
    localparam int unsigned NW = $clog2(D + 1);
    localparam int unsigned CW = $clog2(W);

    function automatic longint unsigned pow10(int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Reject configurations whose digit count cannot hold the largest operand.
    if (W < 4 || W > 16) begin : g_bad_w
        $error("bin2bcd_msd: W=%0d outside 4..16", W);
    end
    if (pow10(D) <= ((64'd1 << W) - 64'd1)) begin : g_bad_d
        $error("bin2bcd_msd: D=%0d digits too few for W=%0d", D, W);
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      sr_q, sr_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [3:0]        msd_q, msd_d;
    logic [NW-1:0]     ndig_q, ndig_d;

    logic [BW-1:0]     acc_adj;
    logic [BW+W-1:0]   shifted;
    logic [BW-1:0]     acc_shift;
    logic [W-1:0]      sr_shift;
    logic [3:0]        msd_calc;
    logic [NW-1:0]     ndig_calc;

    // One double-dabble step: add 3 to every digit >= 5, then shift the pair left.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < int'(D); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        shifted   = {acc_adj, sr_q} << 1;
        acc_shift = shifted[BW+W-1:W];
        sr_shift  = shifted[W-1:0];
    end

    // Ascending scan: the highest non-zero digit is the last one to win.
    always_comb begin
        msd_calc  = 4'd0;
        ndig_calc = NW'(1);
        for (int k = 0; k < int'(D); k++) begin
            if (acc_shift[4*k +: 4] != 4'd0) begin
                msd_calc  = acc_shift[4*k +: 4];
                ndig_calc = NW'(k + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        msd_d   = msd_q;
        ndig_d  = ndig_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StShift;
                    sr_d    = bus.din;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                sr_d  = sr_shift;
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    // Results are published only from the final step, never mid-way.
                    state_d = StDone;
                    cnt_d   = '0;
                    bcd_d   = acc_shift;
                    msd_d   = msd_calc;
                    ndig_d  = ndig_calc;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    state_d = StShift;
                    sr_d    = bus.din;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            msd_q   <= '0;
            ndig_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            msd_q   <= msd_d;
            ndig_q  <= ndig_d;
        end
    end

    assign bus.busy = (state_q == StShift);
    assign bus.done = (state_q == StDone);
    assign bus.bcd  = bcd_q;
    assign bus.msd  = msd_q;
    assign bus.ndig = ndig_q;

    a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);
    a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.busy && bus.done));
    for (genvar g = 0; g < int'(D); g++) begin : g_digit_chk
        a_digit_range : assert property (@(posedge clk) disable iff (!rst_n)
            bcd_q[4*g +: 4] <= 4'd9);
    end
endmodule

// File: tb/tb_bin2bcd_msd.sv
// Directed checks of bin2bcd_msd at W=8/D=3 and W=12/D=4 sharing one clock.
module tb_bin2bcd_msd;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    bin2bcd_msd_if #(.W(8),  .D(3)) a ();
    bin2bcd_msd_if #(.W(12), .D(4)) b ();

    bin2bcd_msd #(.W(8),  .D(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
    bin2bcd_msd #(.W(12), .D(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dec3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] msd3(input int v);
        return (v >= 100) ? 4'(v / 100) : (v >= 10) ? 4'(v / 10) : 4'(v);
    endfunction

    function automatic logic [1:0] ndig3(input int v);
        return (v >= 100) ? 2'd3 : (v >= 10) ? 2'd2 : 2'd1;
    endfunction

    task automatic conv8(input string tag, input logic [7:0] v, input logic [11:0] eb,
                         input logic [3:0] em, input logic [1:0] en);
        int n;
        int nb;
        a.start = 1'b1;
        a.din   = v;
        tick();
        a.start = 1'b0;
        a.din   = ~v;
        n  = 0;
        nb = 0;
        while (a.done !== 1'b1 && n < 20) begin
            if (a.busy === 1'b1) nb++;
            tick();
            n++;
        end
        check({tag, ":latency"}, n, 8);
        check({tag, ":busycycles"}, nb, 8);
        check({tag, ":busy_at_done"}, a.busy, 0);
        check({tag, ":bcd"}, a.bcd, eb);
        check({tag, ":msd"}, a.msd, em);
        check({tag, ":ndig"}, a.ndig, en);
        tick();
        check({tag, ":done_pulse"}, a.done, 0);
        check({tag, ":bcd_hold"}, a.bcd, eb);
    endtask

    task automatic conv12(input string tag, input logic [11:0] v, input logic [15:0] eb,
                          input logic [3:0] em, input logic [2:0] en);
        int n;
        b.start = 1'b1;
        b.din   = v;
        tick();
        b.start = 1'b0;
        b.din   = ~v;
        n = 0;
        while (b.done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, ":latency"}, n, 12);
        check({tag, ":bcd"}, b.bcd, eb);
        check({tag, ":msd"}, b.msd, em);
        check({tag, ":ndig"}, b.ndig, en);
        tick();
    endtask

    initial begin
        int n;
        int saw;
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        a.start = 1'b0;
        a.din   = '0;
        b.start = 1'b0;
        b.din   = '0;
        tick();
        tick();
        check("rst:busy", a.busy, 0);
        check("rst:done", a.done, 0);
        check("rst:bcd", a.bcd, 0);
        check("rst:msd", a.msd, 0);
        check("rst:ndig", a.ndig, 0);
        check("rst12:ndig", b.ndig, 0);

        // Start presented on the very first edge after reset release.
        rst_n = 1'b1;
        conv8("d0", 8'd0, 12'h000, 4'd0, 2'd1);
        conv8("d37", 8'd37, 12'h037, 4'd3, 2'd2);
        conv8("d9", 8'd9, 12'h009, 4'd9, 2'd1);
        conv8("d255", 8'd255, 12'h255, 4'd2, 2'd3);
        conv8("d10", 8'd10, 12'h010, 4'd1, 2'd2);
        conv8("d99", 8'd99, 12'h099, 4'd9, 2'd2);

        // Start during SHIFT must be ignored.
        a.start = 1'b1;
        a.din   = 8'd100;
        tick();
        a.start = 1'b0;
        tick();
        a.start = 1'b1;
        a.din   = 8'd7;
        tick();
        tick();
        a.start = 1'b0;
        a.din   = 8'd0;
        n = 3;
        while (a.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ign:latency", n, 8);
        check("ign:bcd", a.bcd, 12'h100);
        check("ign:msd", a.msd, 4'd1);
        check("ign:ndig", a.ndig, 2'd3);
        tick();
        check("ign:idle", a.busy, 0);

        // Sustained throughput with start held high.
        a.start = 1'b1;
        a.din   = 8'd0;
        tick();
        for (int v = 0; v < 256; v++) begin
            if (v == 255) a.start = 1'b0;
            else a.din = 8'(v + 1);
            n = 0;
            while (a.done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("seq:latency", n, 8);
            check("seq:bcd", a.bcd, dec3(v));
            check("seq:msd", a.msd, msd3(v));
            check("seq:ndig", a.ndig, ndig3(v));
            tick();
            if (v < 255) begin
                check("seq:b2b_busy", a.busy, 1);
                check("seq:b2b_hold", a.bcd, dec3(v));
            end
        end
        check("seq:end_busy", a.busy, 0);
        check("seq:end_done", a.done, 0);

        // Reset in the fourth SHIFT cycle of din=200 aborts cleanly.
        a.start = 1'b1;
        a.din   = 8'd200;
        tick();
        a.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort:busy", a.busy, 0);
        check("abort:done", a.done, 0);
        check("abort:bcd", a.bcd, 0);
        check("abort:msd", a.msd, 0);
        check("abort:ndig", a.ndig, 0);
        saw = 0;
        repeat (12) begin
            if (a.done !== 1'b0) saw = 1;
            tick();
        end
        check("abort:no_done", saw, 0);
        check("abort:bcd_still0", a.bcd, 0);
        conv8("d42", 8'd42, 12'h042, 4'd4, 2'd2);

        conv12("w12_4095", 12'd4095, 16'h4095, 4'd4, 3'd4);
        conv12("w12_1000", 12'd1000, 16'h1000, 4'd1, 3'd4);
        conv12("w12_305", 12'd305, 16'h0305, 4'd3, 3'd3);
        conv12("w12_0", 12'd0, 16'h0000, 4'd0, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bin2bcd_msd.md
BIN2BCD_MSD -- requirements
Module: bin2bcd_msd

Interface
REQ-001 Parameter W, default 8: binary input width, legal range 4..16.
REQ-002 Parameter D, default 3: BCD digit count; SHALL satisfy 10^D > 2^W - 1. An illegal W/D combination SHALL stop elaboration.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  conversion request, sampled on rising edge.
REQ-006 din  input  W  unsigned binary operand, sampled only when start is accepted.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse marking the cycle when a new result is valid.
REQ-009 bcd  output  4*D  packed BCD result; digit k occupies bits [4k+3:4k], k=0 is units.
REQ-010 msd  output  4  most significant non-zero decimal digit of the result; 0 when the result is 0.
REQ-011 ndig  output  clog2(D+1)  number of significant decimal digits; 1 for a zero result, 0 after reset.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE. Transitions:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> DONE after exactly W iterations.
  - DONE -> IDLE unconditionally, or DONE -> SHIFT when start=1.
REQ-013 start is accepted only in IDLE or DONE. Accepting start SHALL:
  - capture din into an internal shift register;
  - clear the BCD accumulator;
  - zero the iteration counter.
REQ-014 start asserted in SHIFT SHALL be ignored: no capture, no restart, no error.
REQ-015 Each SHIFT cycle performs one double-dabble iteration, in this order:
  - every accumulator digit >= 5 gets +3;
  - {accumulator, operand} shifts left by 1, MSB-first.
REQ-016 busy SHALL be 1 in every SHIFT cycle and 0 in IDLE and DONE.
REQ-017 Latency: if start is accepted on edge N, done SHALL be 1 during the cycle after edge N+W, i.e. W+1 clocks after acceptance.
REQ-018 bcd, msd and ndig SHALL update only on entry to DONE. They SHALL hold their values until the next entry to DONE or until reset. Intermediate accumulator values SHALL never appear on the outputs.
REQ-019 msd/ndig derivation: scan digits D-1 down to 0; the first non-zero digit j gives msd = digit j and ndig = j+1. If all digits are zero: msd = 0, ndig = 1.
REQ-020 Back-to-back operation: start accepted in a DONE cycle SHALL begin a new conversion on the next edge. done deasserts, busy asserts, and the previous results stay visible.
REQ-021 Sustained throughput with start held high SHALL be one result per W+1 cycles.
REQ-022 All arithmetic SHALL be unsigned. Every output digit SHALL be in the range 0..9 for every legal din.

Reset
REQ-023 When rst_n=0 at a rising edge:
  - state -> IDLE;
  - busy=0, done=0, bcd=0, msd=0, ndig=0;
  - internal shift register and counter cleared.
REQ-024 Reset SHALL take priority over start and over any in-flight conversion. An aborted conversion SHALL produce no done pulse and leave no partial result.
REQ-025 After rst_n returns high, the block SHALL accept start on the first edge.

Verification (W=8, D=3)
REQ-026 din=0, start pulse -> done 9 cycles later; bcd=12'h000, msd=0, ndig=1; busy high exactly 8 cycles.
REQ-027 din=37 -> bcd=12'h037, msd=3, ndig=2; din=9 -> bcd=12'h009, msd=9, ndig=1; din=255 -> bcd=12'h255, msd=2, ndig=3.
REQ-028 start with din=100, then start with din=7 during SHIFT -> second request ignored; result bcd=12'h100, msd=1, ndig=3.
REQ-029 start held high with din stepping 0..255, one new value at each acceptance -> 256 done pulses spaced 9 cycles apart; each result matches the decimal reference.
REQ-030 rst_n=0 for one cycle at the 4th SHIFT cycle of din=200 -> no done; all outputs 0; a following start with din=42 -> bcd=12'h042, msd=4, ndig=2 after 9 cycles.
REQ-031 Repeat REQ-027 with W=12, D=4 and din=4095 -> bcd=16'h4095, msd=4, ndig=4, done 13 cycles after acceptance.
